// File: rtl/vai_tx_buffer.sv
// Per-sub-AFU Tx request buffer: independent c0/c1 FIFOs drained under the mux slot's
// almost-full, c1 packets issued contiguously, c2 retimed once, Rx passed through.
package vai_ccip_pkg;

    typedef struct packed {
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c0_ReqMemHdr;

    typedef struct packed {
        logic        sop;
        logic [1:0]  cl_len;
        logic [3:0]  req_type;
        logic [41:0] address;
        logic [15:0] mdata;
    } t_ccip_c1_ReqMemHdr;

    typedef struct packed {
        logic [8:0] tid;
    } t_ccip_c2_RspMmioHdr;

    typedef struct packed {
        logic [15:0] mdata;
        logic [3:0]  resp_type;
    } t_ccip_RspHdr;

    typedef struct packed {
        t_ccip_c0_ReqMemHdr hdr;
        logic               valid;
    } t_if_ccip_c0_Tx;

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
        logic               valid;
    } t_if_ccip_c1_Tx;

    typedef struct packed {
        t_ccip_c2_RspMmioHdr hdr;
        logic                mmioRdValid;
        logic [63:0]         data;
    } t_if_ccip_c2_Tx;

    typedef struct packed {
        t_if_ccip_c0_Tx c0;
        t_if_ccip_c1_Tx c1;
        t_if_ccip_c2_Tx c2;
    } t_if_ccip_Tx;

    typedef struct packed {
        t_ccip_RspHdr hdr;
        logic [511:0] data;
        logic         rspValid;
        logic         mmioRdValid;
        logic         mmioWrValid;
    } t_if_ccip_c0_Rx;

    typedef struct packed {
        t_ccip_RspHdr hdr;
        logic         rspValid;
    } t_if_ccip_c1_Rx;

    typedef struct packed {
        logic           c0TxAlmFull;
        logic           c1TxAlmFull;
        t_if_ccip_c0_Rx c0;
        t_if_ccip_c1_Rx c1;
    } t_if_ccip_Rx;

endpackage

module vai_tx_buffer
    import vai_ccip_pkg::*;
#(
    parameter int C0_DEPTH      = 64,
    parameter int C1_DEPTH      = 64,
    parameter int ALMFULL_SLACK = 12
) (
    input  logic        clk,
    input  logic        reset,
    input  t_if_ccip_Tx afu_TxPort,
    output t_if_ccip_Rx afu_RxPort,
    output t_if_ccip_Tx mux_TxPort,
    input  t_if_ccip_Rx mux_RxPort,
    output logic        overflow_err
);

    localparam int C0_AW = $clog2(C0_DEPTH);
    localparam int C0_CW = C0_AW + 1;
    localparam int C1_AW = $clog2(C1_DEPTH);
    localparam int C1_CW = C1_AW + 1;

    localparam logic [C0_CW-1:0] C0_ZERO  = C0_CW'(0);
    localparam logic [C0_CW-1:0] C0_ONE   = C0_CW'(1);
    localparam logic [C0_CW-1:0] C0_FULL  = C0_CW'(C0_DEPTH);
    localparam logic [C0_CW-1:0] C0_AF_TH = C0_CW'(C0_DEPTH - ALMFULL_SLACK);
    localparam logic [C0_AW-1:0] C0_PINC  = C0_AW'(1);
    localparam logic [C1_CW-1:0] C1_ZERO  = C1_CW'(0);
    localparam logic [C1_CW-1:0] C1_ONE   = C1_CW'(1);
    localparam logic [C1_CW-1:0] C1_FULL  = C1_CW'(C1_DEPTH);
    localparam logic [C1_CW-1:0] C1_AF_TH = C1_CW'(C1_DEPTH - ALMFULL_SLACK);
    localparam logic [C1_AW-1:0] C1_PINC  = C1_AW'(1);

    typedef struct packed {
        t_ccip_c1_ReqMemHdr hdr;
        logic [511:0]       data;
    } t_c1_entry;

    typedef enum logic {
        C1_IDLE  = 1'b0,
        C1_BURST = 1'b1
    } t_c1_state;

    t_ccip_c0_ReqMemHdr c0_mem [C0_DEPTH];
    logic [C0_AW-1:0]   c0_wr_ptr_q, c0_wr_ptr_d, c0_rd_ptr_q, c0_rd_ptr_d;
    logic [C0_CW-1:0]   c0_count_q, c0_count_d;
    logic               c0_full_s, c0_push_s, c0_drop_s, c0_pop_s;
    logic               c0_almfull_q;

    t_c1_entry          c1_mem [C1_DEPTH];
    t_c1_entry          c1_head_s;
    logic [C1_AW-1:0]   c1_wr_ptr_q, c1_wr_ptr_d, c1_rd_ptr_q, c1_rd_ptr_d;
    logic [C1_CW-1:0]   c1_count_q, c1_count_d, c1_need_s;
    logic               c1_full_s, c1_push_s, c1_drop_s, c1_pop_s, c1_sop_err_s;
    logic               c1_almfull_q;
    t_c1_state          c1_state_q, c1_state_d;
    logic [1:0]         c1_beats_left_q, c1_beats_left_d;

    t_if_ccip_c0_Tx     mux_c0_q;
    t_if_ccip_c1_Tx     mux_c1_q;
    t_if_ccip_c2_Tx     mux_c2_q;
    logic               overflow_q;

    // c0 push/pop decode; pop looks only at the registered count so it never sees a same-cycle push
    always_comb begin
        c0_full_s   = (c0_count_q == C0_FULL);
        c0_push_s   = afu_TxPort.c0.valid & ~c0_full_s;
        c0_drop_s   = afu_TxPort.c0.valid & c0_full_s;
        c0_pop_s    = (c0_count_q != C0_ZERO) & ~mux_RxPort.c0TxAlmFull;
        c0_wr_ptr_d = c0_push_s ? (c0_wr_ptr_q + C0_PINC) : c0_wr_ptr_q;
        c0_rd_ptr_d = c0_pop_s ? (c0_rd_ptr_q + C0_PINC) : c0_rd_ptr_q;
        case ({c0_push_s, c0_pop_s})
            2'b10:   c0_count_d = c0_count_q + C0_ONE;
            2'b01:   c0_count_d = c0_count_q - C0_ONE;
            default: c0_count_d = c0_count_q;
        endcase
    end

    // c0 storage
    always_ff @(posedge clk) begin
        if (c0_push_s) begin
            c0_mem[c0_wr_ptr_q] <= afu_TxPort.c0.hdr;
        end
    end

    // c0 pointers, count, almost-full flag and issue register
    always_ff @(posedge clk) begin
        if (reset) begin
            c0_wr_ptr_q  <= {C0_AW{1'b0}};
            c0_rd_ptr_q  <= {C0_AW{1'b0}};
            c0_count_q   <= C0_ZERO;
            c0_almfull_q <= 1'b1;
            mux_c0_q     <= '0;
        end else begin
            c0_wr_ptr_q    <= c0_wr_ptr_d;
            c0_rd_ptr_q    <= c0_rd_ptr_d;
            c0_count_q     <= c0_count_d;
            c0_almfull_q   <= (c0_count_d >= C0_AF_TH);
            mux_c0_q.valid <= c0_pop_s;
            mux_c0_q.hdr   <= c0_mem[c0_rd_ptr_q];
        end
    end

    // c1 push decode and pointer/count next state
    always_comb begin
        c1_head_s   = c1_mem[c1_rd_ptr_q];
        c1_full_s   = (c1_count_q == C1_FULL);
        c1_push_s   = afu_TxPort.c1.valid & ~c1_full_s;
        c1_drop_s   = afu_TxPort.c1.valid & c1_full_s;
        c1_wr_ptr_d = c1_push_s ? (c1_wr_ptr_q + C1_PINC) : c1_wr_ptr_q;
        c1_rd_ptr_d = c1_pop_s ? (c1_rd_ptr_q + C1_PINC) : c1_rd_ptr_q;
        case ({c1_push_s, c1_pop_s})
            2'b10:   c1_count_d = c1_count_q + C1_ONE;
            2'b01:   c1_count_d = c1_count_q - C1_ONE;
            default: c1_count_d = c1_count_q;
        endcase
    end

    // c1 drain FSM: a packet starts only when fully buffered, then ignores throttling until done
    always_comb begin
        c1_state_d      = c1_state_q;
        c1_beats_left_d = c1_beats_left_q;
        c1_pop_s        = 1'b0;
        c1_sop_err_s    = 1'b0;
        c1_need_s       = C1_CW'(c1_head_s.hdr.cl_len) + C1_ONE;
        case (c1_state_q)
            C1_IDLE: begin
                if ((c1_count_q != C1_ZERO) && !mux_RxPort.c1TxAlmFull) begin
                    if (!c1_head_s.hdr.sop) begin
                        c1_pop_s     = 1'b1;
                        c1_sop_err_s = 1'b1;
                    end else if (c1_count_q >= c1_need_s) begin
                        c1_pop_s = 1'b1;
                        if (c1_head_s.hdr.cl_len != 2'd0) begin
                            c1_beats_left_d = c1_head_s.hdr.cl_len;
                            c1_state_d      = C1_BURST;
                        end else begin
                            c1_state_d = C1_IDLE;
                        end
                    end else begin
                        c1_pop_s = 1'b0;
                    end
                end else begin
                    c1_pop_s = 1'b0;
                end
            end
            C1_BURST: begin
                c1_pop_s        = 1'b1;
                c1_beats_left_d = c1_beats_left_q - 2'd1;
                if (c1_beats_left_q == 2'd1) begin
                    c1_state_d = C1_IDLE;
                end else begin
                    c1_state_d = C1_BURST;
                end
            end
            default: begin
                c1_state_d      = C1_IDLE;
                c1_beats_left_d = 2'd0;
            end
        endcase
    end

    // c1 storage
    always_ff @(posedge clk) begin
        if (c1_push_s) begin
            c1_mem[c1_wr_ptr_q] <= '{hdr: afu_TxPort.c1.hdr, data: afu_TxPort.c1.data};
        end
    end

    // c1 pointers, count, FSM state, almost-full flag and issue register
    always_ff @(posedge clk) begin
        if (reset) begin
            c1_wr_ptr_q     <= {C1_AW{1'b0}};
            c1_rd_ptr_q     <= {C1_AW{1'b0}};
            c1_count_q      <= C1_ZERO;
            c1_almfull_q    <= 1'b1;
            c1_state_q      <= C1_IDLE;
            c1_beats_left_q <= 2'd0;
            mux_c1_q        <= '0;
        end else begin
            c1_wr_ptr_q     <= c1_wr_ptr_d;
            c1_rd_ptr_q     <= c1_rd_ptr_d;
            c1_count_q      <= c1_count_d;
            c1_almfull_q    <= (c1_count_d >= C1_AF_TH);
            c1_state_q      <= c1_state_d;
            c1_beats_left_q <= c1_beats_left_d;
            mux_c1_q.valid  <= c1_pop_s;
            mux_c1_q.hdr    <= c1_head_s.hdr;
            mux_c1_q.data   <= c1_head_s.data;
        end
    end

    // c2 retiming and sticky error flag
    always_ff @(posedge clk) begin
        if (reset) begin
            mux_c2_q   <= '0;
            overflow_q <= 1'b0;
        end else begin
            mux_c2_q   <= afu_TxPort.c2;
            overflow_q <= overflow_q | c0_drop_s | c1_drop_s | c1_sop_err_s;
        end
    end

    // Rx pass-through with this buffer's own almost-full flags substituted
    always_comb begin
        afu_RxPort             = mux_RxPort;
        afu_RxPort.c0TxAlmFull = c0_almfull_q;
        afu_RxPort.c1TxAlmFull = c1_almfull_q;
    end

    assign mux_TxPort.c0 = mux_c0_q;
    assign mux_TxPort.c1 = mux_c1_q;
    assign mux_TxPort.c2 = mux_c2_q;
    assign overflow_err  = overflow_q;

endmodule

// File: doc/vai_tx_buffer.md
# vai_tx_buffer

Per-sub-AFU Tx request buffer placed between one sub-AFU and its slot of the VAI multiplexer (the slot whose Tx requests are audited and offset-translated before arbitration). It absorbs c0 (read) and c1 (write) requests in independent FIFOs and drains them under the multiplexer's per-slot almost-full. It issues multi-beat writes only as contiguous packets and presents the sub-AFU with its own almost-full, sized for CCI-P request slack. c2 MMIO responses are retimed by one register stage; Rx responses pass straight through to the sub-AFU.

## Interface
- C0_DEPTH, 64: c0 FIFO entries; power of two, ≥ 16.
- C1_DEPTH, 64: c1 FIFO entries; power of two, ≥ 16.
- ALMFULL_SLACK, 12: free entries remaining when almost-full asserts; must be ≥ 10 (8 CCI-P post-almFull requests + 2 cycles of registered-flag lag).

- clk  input  1  single clock for all logic.
- reset  input  1  synchronous, active-high.
- afu_TxPort  input  t_if_ccip_Tx  requests from the sub-AFU.
- afu_RxPort  output  t_if_ccip_Rx  responses to the sub-AFU; almost-full bits come from this block.
- mux_TxPort  output  t_if_ccip_Tx  requests to the mux slot.
- mux_RxPort  input  t_if_ccip_Rx  responses from the mux slot, including per-slot almost-full.
- overflow_err  output  1  sticky; set when a request arrives while its FIFO is full.

## Operation
- Enqueue: afu_TxPort.c0.valid pushes {hdr} into the c0 FIFO; afu_TxPort.c1.valid pushes {hdr, data} into the c1 FIFO. The two channels are independent and may push in the same cycle.
- Full push: the request is dropped, FIFO contents are unchanged, and overflow_err is set until reset.
- c0 drain: the head is issued when the c0 FIFO is non-empty and mux_RxPort.c0TxAlmFull is 0. At most 1 per cycle.
- c1 drain FSM, with states C1_IDLE and C1_BURST and a 2-bit beats_left counter:
  - C1_IDLE, head sop=1, cl_len=L (0, 1 or 3 → 1, 2 or 4 beats): issue only if c1 count ≥ L+1 and mux_RxPort.c1TxAlmFull is 0. If L>0, load beats_left=L and go to C1_BURST.
  - C1_IDLE, head sop=0: this is a protocol error. Issue it as a single beat and set overflow_err.
  - C1_BURST: issue 1 beat every cycle regardless of mux almost-full (the packet must stay contiguous). Decrement beats_left; return to C1_IDLE when it reaches 0.
- c2: mux_TxPort.c2 is afu_TxPort.c2 registered once.
- Rx: afu_RxPort is mux_RxPort combinationally, except c0TxAlmFull and c1TxAlmFull, which are this block's registered flags.
- Almost-full: a flag is 1 when the channel count ≥ DEPTH − ALMFULL_SLACK, computed from the post-update count and registered.
- Simultaneous push and pop: the count is unchanged. Push to an empty FIFO plus pop in the same cycle is impossible, because pop uses the registered head.
- Count width is clog2(DEPTH)+1; it never wraps. Pointers wrap modulo DEPTH.

## Timing
- Registered outputs: mux_TxPort.c0, .c1 and .c2, both almost-full flags, and overflow_err.
- Minimum latency: a request pushed in cycle N appears on mux_TxPort in cycle N+2.
- Throughput: 1 request per channel per cycle sustained when the mux is not throttling.
- A 4-beat write completely buffered issues on 4 consecutive cycles.
- Mux almost-full rising in cycle N blocks new issues from cycle N onward; an in-progress burst still completes.
- Reset values: all mux_TxPort valids 0, both afu_RxPort almost-full flags 1, overflow_err 0, FIFOs empty, FSM in C1_IDLE. Almost-full flags fall in the first cycle after reset deasserts.
- Reset mid-burst: remaining beats are discarded and the next issue after reset starts at a new sop.

## Test plan
- Reset, then 1 read with mux almFull=0 → mux c0 valid in exactly the 2nd cycle after the push, header bit-identical; afu almFull flags are 1 during reset and 0 one cycle after.
- Hold mux c0 almFull=1 and push 52 reads (DEPTH 64, slack 12) → afu c0TxAlmFull rises the cycle after the 52nd push. Push 12 more reads (64 total), then 1 more → overflow_err=1. Release almFull → exactly 64 reads drain in order, 1 per cycle.
- Push a 4-beat write (cl_len=3) one beat every other cycle → no c1 valid until all 4 beats are buffered, then 4 consecutive beats in order.
- Start a 4-beat burst and raise mux c1 almFull on beat 2 → beats 3 and 4 still issue on consecutive cycles; the next packet waits for almFull=0.
- Push a read and a write in the same cycle, then push 1 beat while popping → both channels issue independently and counts stay exact (checked against a reference model).
- Assert reset mid-burst after beat 2 → no further c1 beats; after reset the next write issues with sop=1 and overflow_err=0.
